// File: rtl/encoder_emulator.sv
// encoder_emulator: programmable-rate angular-encoder square-wave source with load handshake; optional ENC_SWEEP_EN half-period sweep
module encoder_emulator #(
  parameter int HALF_W       = 16,
  parameter int DEFAULT_HALF = 260,
  parameter int SWEEP_MIN    = 40
) (
  input  logic              AE_CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic [HALF_W-1:0] Half_Period,
  input  logic              Load,
  output logic              Load_Ack,
  output logic              AngularEncoder,
  output logic              Edge_Pulse,
  output logic [HALF_W-1:0] Edge_Count,
  output logic              Busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [HALF_W-1:0] cnt, active_half, pend, cur, eff;
  logic pend_valid, tog, start;
  assign eff   = pend_valid ? pend : active_half;
  assign start = state == IDLE && Enable && eff != '0;
  assign tog   = state == RUN && Enable && cnt == cur - HALF_W'(1);
  assign Busy  = state == RUN;
`ifdef ENC_SWEEP_EN
  logic phase;
  // sweep the running half-period from SWEEP_MIN up to the committed ceiling, one step per full period
  always_ff @(posedge AE_CLK or posedge RST)
    if (RST) begin
      cur   <= HALF_W'(DEFAULT_HALF);
      phase <= 1'b0;
    end else if (start) begin
      cur   <= eff <= HALF_W'(SWEEP_MIN) ? eff : HALF_W'(SWEEP_MIN);
      phase <= 1'b0;
    end else if (tog) begin
      phase <= ~phase;
      if (phase)
        cur <= eff <= HALF_W'(SWEEP_MIN) ? eff : cur >= eff ? HALF_W'(SWEEP_MIN) : cur + HALF_W'(1);
    end
`else
  assign cur = active_half;
`endif
  // run/idle control, half-period counting, pending-load commit and handshake
  always_ff @(posedge AE_CLK or posedge RST)
    if (RST) begin
      state          <= IDLE;
      cnt            <= '0;
      active_half    <= HALF_W'(DEFAULT_HALF);
      pend           <= '0;
      pend_valid     <= 1'b0;
      AngularEncoder <= 1'b0;
      Edge_Pulse     <= 1'b0;
      Edge_Count     <= '0;
      Load_Ack       <= 1'b0;
    end else begin
      Load_Ack   <= Load;
      Edge_Pulse <= tog;
      if (state == IDLE) begin
        cnt <= '0;
        if (start) begin
          state       <= RUN;
          active_half <= eff;
          pend_valid  <= 1'b0;
        end
      end else if (!Enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (tog) begin
        cnt            <= '0;
        AngularEncoder <= ~AngularEncoder;
        Edge_Count     <= Edge_Count + HALF_W'(1);
        if (pend_valid) begin
          active_half <= pend;
          pend_valid  <= 1'b0;
          if (pend == '0) state <= IDLE;
        end
      end else begin
        cnt <= cnt + HALF_W'(1);
      end
      // a load sampled on a commit edge survives as the next pending value
      if (Load) begin
        pend       <= Half_Period;
        pend_valid <= 1'b1;
      end
    end
endmodule

// File: doc/encoder_emulator.md
Name: encoder_emulator

Overview:
- Synthesizable angular-encoder signal source: generates the square wave on AngularEncoder at a programmed half-period measured in AE_CLK cycles.
- Intended to drive SpeedController's encoder input for hardware-in-loop and closed-loop bench runs without a physical wheel.
- New rates are loaded through a strobe/ack handshake and applied glitch-free at the next edge.
- Also reports edge events and a running edge count.

Parameters:
- HALF_W, 16, width of half-period and edge-count registers.
- DEFAULT_HALF, 260, half-period in AE_CLK cycles loaded at reset.
- SWEEP_MIN, 40, lower sweep bound in cycles (used only with ENC_SWEEP_EN).

Ports:
- AE_CLK  in  1  sole clock, all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- Enable  in  1  run/stop.
- Half_Period  in  HALF_W  requested half-period in AE_CLK cycles.
- Load  in  1  single-cycle strobe; captures Half_Period.
- Load_Ack  out  1  one-cycle pulse acknowledging a Load.
- AngularEncoder  out  1  emulated encoder square wave.
- Edge_Pulse  out  1  one-cycle pulse on the cycle AngularEncoder toggles.
- Edge_Count  out  HALF_W  count of toggles, wraps modulo 2^HALF_W.
- Busy  out  1  high while in RUN.

Behaviour:
- Reset values:
  - AngularEncoder=0, Edge_Pulse=0, Load_Ack=0, Edge_Count=0, Busy=0.
  - Internal: cnt=0, active_half=DEFAULT_HALF, pend_valid=0, state=IDLE.
- States:
  - IDLE -> RUN when Enable=1 and effective half != 0. Effective half is pend value if pend_valid, else active_half.
  - On the IDLE->RUN transition, a pending value is committed to active_half and pend_valid clears.
  - RUN -> IDLE when Enable=0, or when a commit sets active_half=0.
- RUN counting:
  - cnt increments each cycle.
  - When cnt==active_half-1: toggle AngularEncoder, cnt<=0, Edge_Pulse=1 on that same registered cycle, Edge_Count+1.
  - The first toggle after entering RUN occurs active_half cycles later.
  - active_half=1 toggles every cycle.
- Load handshake:
  - Load=1 captures Half_Period into pend and sets pend_valid.
  - Load_Ack=1 on the following cycle.
  - Back-to-back Loads: last value wins; one Ack per Load.
- Commit:
  - In RUN, a pending value commits on a toggle cycle only, so the current half-period always completes.
  - A Load coinciding with a toggle cycle is not applied at that toggle; it commits at the next one.
  - In IDLE, the commit happens on the IDLE->RUN transition.
- Enable=0: cnt cleared to 0, AngularEncoder level held, no Edge_Pulse. Pending load retained.
- Half_Period=0: stop. It commits at the next toggle, then AngularEncoder holds and the block moves to IDLE.
- Edge_Count wraps from 2^HALF_W-1 to 0 without a flag.
- RST mid-operation: all state returns to reset values immediately (asynchronous). Pending loads are discarded.

Optional Feature:
- Macro ENC_SWEEP_EN.
- Defined:
  - active_half acts as the sweep ceiling; the running half-period cur starts at SWEEP_MIN on entering RUN.
  - cur increments by 1 after every second toggle (each full period).
  - On reaching the ceiling, cur wraps back to SWEEP_MIN on the next full-period boundary.
  - If the ceiling is <= SWEEP_MIN, cur stays fixed at the ceiling.
  - Loads change the ceiling via the normal commit rule.
- Undefined: cur is always active_half; no sweep logic is synthesized.

Test Plan:
- Reset then Enable=1, no Load -> first toggle at cycle 260 after Enable, then every 260 cycles; Edge_Count=4 after 1040 cycles; Busy=1.
- Load Half_Period=10 mid-half-period at cnt=100 -> Load_Ack next cycle; current half completes at 260; subsequent toggles every 10 cycles.
- Load=1 on exact toggle cycle with value 5, then Load 7 one cycle later -> two Acks; next half-period unchanged; following half-periods are 7.
- Enable=0 for 50 cycles at cnt=30, level=1 -> AngularEncoder stays 1, no Edge_Pulse; re-enable gives first toggle 260 cycles later.
- Load 0 while running -> current half completes, one final toggle, then output holds, Busy=0; Load 3 afterwards gives toggles every 3 cycles.
- RST pulse mid-half-period with pend_valid=1 -> outputs 0 immediately; after release and Enable=1, half-period is 260 (pending discarded).
- ENC_SWEEP_EN defined, ceiling 43 -> half-periods 40,40,41,41,42,42,43,43,40,40 in sequence.
